// File: rtl/xor_parity_encoder.sv
// xor_parity_encoder
//
// Pops 32-bit words from the raw-data-out FIFO in groups of four. Each word is
// forwarded unchanged to the encoded-data FIFO, tagged with its position in
// the group. After the fourth word, one XOR parity word is appended, so each
// encoded block is five words long. Also counts completed blocks for status.
//
// Ports
//   clk                      single clock, rising edge
//   reset                    asynchronous, active-low reset
//   raw_data_out_fifo_empty  upstream FIFO has no word at its head
//   raw_data_out_fifo_dout   upstream head word (first-word-fall-through)
//   raw_data_out_fifo_pop    consume the upstream head word this cycle
//   encoding                 upstream FSM is mid-group (status only)
//   enc_fifo_full            encoded-data FIFO cannot take a push this cycle
//   enc_fifo_clr             synchronous clear of the encoded-data FIFO
//   enc_fifo_push            write din/tag/last this cycle
//   enc_fifo_din             data word or parity word
//   enc_fifo_tag             0..3 = data word index, 4 = parity word
//   enc_fifo_last            high only together with the parity push
//   group_count              completed blocks since reset, wraps silently
//   busy                     group partially processed, or upstream encoding

module xor_parity_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  raw_data_out_fifo_empty,
  input  logic [DATA_WIDTH-1:0] raw_data_out_fifo_dout,
  output logic                  raw_data_out_fifo_pop,
  input  logic                  encoding,
  input  logic                  enc_fifo_full,
  output logic                  enc_fifo_clr,
  output logic                  enc_fifo_push,
  output logic [DATA_WIDTH-1:0] enc_fifo_din,
  output logic [2:0]            enc_fifo_tag,
  output logic                  enc_fifo_last,
  output logic [CNT_WIDTH-1:0]  group_count,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b100
  } state_t;

  localparam logic [2:0] PARITY_TAG = 3'd4;

  state_t                state;
  logic [1:0]            index;
  logic [DATA_WIDTH-1:0] parity;
  logic                  data_xfer;

  // A data word moves only when there is one to take and room to put it.
  assign data_xfer = (state == ST_DATA) && !raw_data_out_fifo_empty && !enc_fifo_full;

  // Mealy outputs: the head word is pushed in the same cycle it is popped.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    raw_data_out_fifo_pop = 1'b0;
    enc_fifo_push         = 1'b0;
    enc_fifo_clr          = 1'b0;
    enc_fifo_din          = '0;
    enc_fifo_tag          = '0;
    enc_fifo_last         = 1'b0;
    case (state)
      // Reset parks the FSM in INIT; gating with reset keeps clr low while
      // reset is held so the clear pulse lands on the first cycle after release.
      ST_INIT: enc_fifo_clr = reset;
      ST_DATA: begin
        if (data_xfer) begin
          raw_data_out_fifo_pop = 1'b1;
          enc_fifo_push         = 1'b1;
          enc_fifo_din          = raw_data_out_fifo_dout;
          enc_fifo_tag          = {1'b0, index};
        end
      end
      ST_PARITY: begin
        if (!enc_fifo_full) begin
          enc_fifo_push = 1'b1;
          enc_fifo_din  = parity;
          enc_fifo_tag  = PARITY_TAG;
          enc_fifo_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state       <= ST_INIT;
      index       <= '0;
      parity      <= '0;
      group_count <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          index  <= '0;
          parity <= '0;
          state  <= ST_DATA;
        end
        ST_DATA: begin
          if (data_xfer) begin
            parity <= parity ^ raw_data_out_fifo_dout;
            if (index == 2'd3) begin
              index <= '0;
              state <= ST_PARITY;
            end else begin
              index <= index + 2'd1;
            end
          end
        end
        ST_PARITY: begin
          if (!enc_fifo_full) begin
            parity      <= '0;
            group_count <= group_count + CNT_WIDTH'(1);
            state       <= ST_DATA;
          end
        end
        // Any corrupted one-hot encoding restarts through INIT, which also
        // clears the downstream FIFO of the partial block.
        default: state <= ST_INIT;
      endcase
    end
  end

  assign busy = (index != 2'd0) || (state == ST_PARITY) || encoding;

endmodule

// File: tb/tb_xor_parity_encoder.sv
module tb_xor_parity_encoder;

  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int CW_S = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          encoding;
  logic          enc_full;

  logic          pop, clr, push, last, busy;
  logic [DW-1:0] din;
  logic [2:0]    tag;
  logic [CW-1:0] gcount;

  // Narrow-counter instance on the same stimulus, used to observe the wrap.
  logic            s_pop, s_clr, s_push, s_last, s_busy;
  logic [DW-1:0]   s_din;
  logic [2:0]      s_tag;
  logic [CW_S-1:0] s_gcount;

  xor_parity_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(rst_n),
    .raw_data_out_fifo_empty(fifo_empty), .raw_data_out_fifo_dout(fifo_dout),
    .raw_data_out_fifo_pop(pop), .encoding(encoding), .enc_fifo_full(enc_full),
    .enc_fifo_clr(clr), .enc_fifo_push(push), .enc_fifo_din(din),
    .enc_fifo_tag(tag), .enc_fifo_last(last), .group_count(gcount), .busy(busy)
  );

  xor_parity_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_S)) dut_wrap (
    .clk(clk), .reset(rst_n),
    .raw_data_out_fifo_empty(fifo_empty), .raw_data_out_fifo_dout(fifo_dout),
    .raw_data_out_fifo_pop(s_pop), .encoding(encoding), .enc_fifo_full(enc_full),
    .enc_fifo_clr(s_clr), .enc_fifo_push(s_push), .enc_fifo_din(s_din),
    .enc_fifo_tag(s_tag), .enc_fifo_last(s_last), .group_count(s_gcount), .busy(s_busy)
  );

  typedef struct {
    logic [DW-1:0] din;
    logic [2:0]    tag;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] up_q[$];
  int            push_cyc[$];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            pop_cnt  = 0;
  int            push_cnt = 0;
  int            cyc      = 0;
  bit            pop_seen = 1'b0;
  bit            hold_empty;
  bit            rec_on;
  int            grp_idx;
  logic [DW-1:0] grp_par;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty = hold_empty || (up_q.size() == 0);
    fifo_dout  = (up_q.size() > 0) ? up_q[0] : '0;
  endtask

  // Queue a word upstream and record the outputs it must produce downstream.
  task automatic feed(input logic [DW-1:0] w);
    exp_t e;
    up_q.push_back(w);
    e.din  = w;
    e.tag  = 3'(grp_idx);
    e.last = 1'b0;
    sb.push_back(e);
    grp_par = grp_par ^ w;
    grp_idx++;
    if (grp_idx == 4) begin
      e.din  = grp_par;
      e.tag  = 3'd4;
      e.last = 1'b1;
      sb.push_back(e);
      grp_idx = 0;
      grp_par = '0;
    end
    refresh();
  endtask

  // Advance one cycle; upstream FIFO consumes its head if the DUT popped.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen && up_q.size() > 0) up_q.delete(0);
    pop_seen = 1'b0;
    refresh();
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (up_q.size() == 0 && sb.size() == 0) break;
      step();
    end
    check(name, up_q.size() + sb.size(), 0);
  endtask

  task automatic wait_q_empty(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (up_q.size() == 0) break;
      step();
    end
    check(name, up_q.size(), 0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    pop_seen = pop;
    if (rst_n) begin
      if (pop) pop_cnt++;
      if (enc_full) check("no_pop_push_while_full", {pop, push}, 0);
      if (fifo_empty) check("no_pop_while_empty", pop, 0);
      if (push) begin
        push_cnt++;
        if (rec_on) push_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_push", push, 0);
        end else begin
          e = sb.pop_front();
          check("push_din", din, e.din);
          check("push_tag", tag, e.tag);
          check("push_last", last, e.last);
          check("pop_with_data_push", pop, e.tag != 3'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, qc;
    rst_n = 1'b0; encoding = 1'b0; enc_full = 1'b0; hold_empty = 1'b0;
    grp_idx = 0; grp_par = '0; rec_on = 1'b0;
    refresh();

    // Reset: outputs quiet, busy follows encoding.
    repeat (2) @(negedge clk) check("reset_outputs_zero", {pop, push, clr, last, tag, din}, 0);
    encoding = 1'b1;
    @(negedge clk);
    check("reset_busy_follows_enc", busy, 1);
    encoding = 1'b0;
    #1 check("reset_busy_low", busy, 0);
    check("reset_group_count", gcount, 0);

    // Group 1 is already waiting upstream when reset releases.
    feed(32'h0000_0001); feed(32'h0000_0002); feed(32'h0000_0004); feed(32'h0000_0008);
    @(negedge clk) check("reset_outputs_with_data", {pop, push, clr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rec_on = 1'b1;
    @(negedge clk);
    check("clr_first_cycle", clr, 1);
    check("no_pop_in_first_cycle", pop, 0);
    @(negedge clk);
    check("clr_single_cycle", clr, 0);
    check("first_pop_second_cycle", pop, 1);
    wait_idle(40, "g1_drain");
    rec_on = 1'b0;
    check("g1_push_count", push_cyc.size(), 5);
    for (int i = 1; i < push_cyc.size(); i++) check("g1_back_to_back", push_cyc[i] - push_cyc[i-1], 1);
    check("g1_group_count", gcount, 1);

    // busy driven by encoding alone while idle.
    encoding = 1'b1; step();
    check("busy_encoding_idle", busy, 1);
    encoding = 1'b0; step();
    check("idle_not_busy", busy, 0);

    // Full in DATA after the second word: nothing moves for 3 cycles.
    feed(32'h0000_0001); feed(32'h0000_0002);
    wait_q_empty(20, "stall_first_half");
    enc_full = 1'b1;
    feed(32'h0000_0004); feed(32'h0000_0008);
    pc = pop_cnt; qc = push_cnt;
    repeat (3) step();
    check("stall_no_pop", pop_cnt - pc, 0);
    check("stall_no_push", push_cnt - qc, 0);
    check("stall_index_held", dut.index, 2);
    enc_full = 1'b0;
    wait_idle(40, "stall_drain");
    check("stall_group_count", gcount, 2);

    // Full on entry to PARITY for 5 cycles.
    feed(32'h0000_0001); feed(32'h0000_0002); feed(32'h0000_0004); feed(32'h0000_0008);
    wait_q_empty(20, "par_words_taken");
    enc_full = 1'b1;
    check("par_busy", busy, 1);
    pc = pop_cnt; qc = push_cnt;
    repeat (5) step();
    check("par_stall_no_push", push_cnt - qc, 0);
    enc_full = 1'b0;
    wait_idle(20, "par_drain");
    check("par_no_extra_pop", pop_cnt - pc, 0);
    check("par_group_count", gcount, 3);

    // Empty for 10 cycles after the second word.
    feed(32'hDEAD_BEEF); feed(32'h1234_5678);
    wait_q_empty(20, "empty_first_half");
    hold_empty = 1'b1;
    feed(32'h0F0F_0F0F); feed(32'hFFFF_0000);
    pc = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      check("empty_busy", busy, 1);
      check("empty_index_held", dut.index, 2);
    end
    check("empty_no_pop", pop_cnt - pc, 0);
    hold_empty = 1'b0;
    refresh();
    wait_idle(40, "empty_drain");
    check("empty_group_count", gcount, 4);

    // All-zero block, then random blocks up to 8 groups (narrow counter wraps).
    for (int i = 0; i < 4; i++) feed('0);
    wait_idle(40, "zero_drain");
    for (int g = 0; g < 3; g++) begin
      if (g == 2) check("wrap_count_before", s_gcount, 7);
      for (int i = 0; i < 4; i++) feed($urandom);
      wait_idle(40, "rand_drain");
    end
    check("wrap_count_zero", s_gcount, 0);
    check("main_count_eight", gcount, 8);

    // Reset after word 3: partial group discarded.
    feed(32'hAAAA_0001); feed(32'hAAAA_0002); feed(32'hAAAA_0004);
    wait_idle(40, "partial_drain");
    rst_n = 1'b0;
    grp_idx = 0; grp_par = '0;
    up_q.delete();
    sb.delete();
    refresh();
    @(negedge clk);
    check("midreset_outputs_zero", {pop, push, clr, last}, 0);
    check("midreset_group_count", gcount, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_clr", clr, 1);
    feed(32'h1357_9BDF); feed(32'h2468_ACE0); feed(32'h0000_FFFF); feed(32'h8000_0001);
    wait_idle(40, "after_reset_drain");
    check("after_reset_group_count", gcount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
